// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter.
//   arb_state_e : 2-bit FSM state encoding (idle, fetch on bus, data on bus, response)
//   arb_sel_e   : priority select code naming the winning requester
//   pick_winner : data-first priority with a forced fetch grant when fetch is starved
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUS_IF = 2'd1,
        ARB_BUS_D  = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        SEL_FETCH = 1'b0,
        SEL_DATA  = 1'b1
    } arb_sel_e;

    // Data wins whenever it asks, except when fetch is also waiting and has
    // already been passed over the maximum number of times in a row.
    function automatic arb_sel_e pick_winner(input logic if_req,
                                             input logic d_req,
                                             input logic starved);
        if (d_req && !(if_req && starved)) begin
            return SEL_DATA;
        end
        return SEL_FETCH;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory bus between the instruction-fetch port
// (reads only) and the data port (reads and writes). One transaction is in
// flight at a time; completion is signalled with a one-cycle valid pulse.
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   if_req/if_addr                  : fetch request (held until if_valid)
//   if_rdata/if_valid               : fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata       : data request (held until d_valid)
//   d_rdata/d_valid                 : load data (reads only) and completion pulse
//   bus_req/bus_we/bus_addr/bus_wdata: memory bus request, held until bus_ack
//   bus_ack/bus_rdata               : memory completion and read data
// All outputs come straight from registers.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
    logic              if_valid_reg, if_valid_next;
    logic              d_valid_reg, d_valid_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

    logic     starved;
    arb_sel_e winner;

    assign starved = (starve_cnt_reg == CNT_W'(STARVE_MAX));
    assign winner  = pick_winner(if_req, d_req, starved);

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        bus_req_next    = bus_req_reg;
        bus_we_next     = bus_we_reg;
        bus_addr_next   = bus_addr_reg;
        bus_wdata_next  = bus_wdata_reg;
        if_valid_next   = 1'b0;
        d_valid_next    = 1'b0;
        if_rdata_next   = if_rdata_reg;
        d_rdata_next    = d_rdata_reg;

        unique case (state_reg)
            ARB_IDLE: begin
                if (if_req || d_req) begin
                    bus_req_next = 1'b1;
                    if (winner == SEL_DATA) begin
                        bus_we_next    = d_we;
                        bus_addr_next  = d_addr;
                        bus_wdata_next = d_wdata;
                        state_next     = ARB_BUS_D;
                        // A data grant only counts against fetch if fetch was
                        // actually waiting; the cap is guaranteed by pick_winner.
                        starve_cnt_next = if_req ? starve_cnt_reg + CNT_W'(1) : '0;
                    end else begin
                        bus_we_next     = 1'b0;
                        bus_addr_next   = if_addr;
                        bus_wdata_next  = '0;
                        state_next      = ARB_BUS_IF;
                        starve_cnt_next = '0;
                    end
                end
            end
            ARB_BUS_IF: begin
                if (bus_ack) begin
                    bus_req_next  = 1'b0;
                    if_rdata_next = bus_rdata;
                    if_valid_next = 1'b1;
                    state_next    = ARB_RESP;
                end
            end
            ARB_BUS_D: begin
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    if (!bus_we_reg) begin
                        d_rdata_next = bus_rdata;
                    end
                    d_valid_next = 1'b1;
                    state_next   = ARB_RESP;
                end
            end
            ARB_RESP: begin
                // Requester sees valid this cycle; give it one cycle to drop
                // or replace its request before arbitrating again.
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            starve_cnt_reg <= '0;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= '0;
            bus_wdata_reg  <= '0;
            if_valid_reg   <= 1'b0;
            d_valid_reg    <= 1'b0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            bus_req_reg    <= bus_req_next;
            bus_we_reg     <= bus_we_next;
            bus_addr_reg   <= bus_addr_next;
            bus_wdata_reg  <= bus_wdata_next;
            if_valid_reg   <= if_valid_next;
            d_valid_reg    <= d_valid_next;
            if_rdata_reg   <= if_rdata_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign if_valid  = if_valid_reg;
    assign d_valid   = d_valid_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule
